lzw_code_packer: RTL and testbench
==================================

Name: lzw_code_packer

Overview:
- Output stage directly downstream of the LZW register/datapath block. It consumes the 12-bit dictionary codes that block presents on its code output.
- Codes are captured into a small FIFO, then packed MSB-first into an 8-bit byte stream with valid/ready handshake for the output file/UART writer.
- Two codes always become three bytes. A flush emits any leftover half-byte zero-padded, then signals completion.

Parameters:
- CODE_W, 12, code width (fixed packing scheme assumes 12)
- FIFO_DEPTH, 4, code FIFO entries; power of two, >=2
- COUNT_W, 24, width of byte counter (optional feature)

Ports:
- Clk  input  1  clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- iCode  input  CODE_W  code from datapath
- CodeValid  input  1  one-cycle strobe: iCode valid
- CodeReady  output  1  FIFO not full
- Flush  input  1  one-cycle strobe: end of stream
- FlushDone  output  1  one-cycle pulse: all data emitted
- oByte  output  8  packed byte
- ByteValid  output  1  oByte valid
- ByteReady  input  1  downstream accepts oByte
- Overflow  output  1  sticky: code dropped
- oByteCount  output  COUNT_W  accepted byte count (optional feature)

Behaviour:
- Reset (async, active-high): FIFO empty, FSM S_EMPTY, oByte=0, ByteValid=0, CodeReady=1, FlushDone=0, Overflow=0, oByteCount=0, flush-pending cleared. Reset mid-stream discards all buffered data.
- FIFO write:
  - CodeValid=1 with count<FIFO_DEPTH: iCode written.
  - CodeValid=1 while full: code dropped, Overflow set (cleared only by Reset).
  - CodeReady = (count<FIFO_DEPTH), based on registered count; a same-cycle pop does not admit a push into a full FIFO.
- Output register: one entry, loadable when (!ByteValid || ByteReady). oByte/ByteValid held stable while ByteValid=1 and ByteReady=0. A byte is transferred on an edge with ByteValid&&ByteReady.
- Packer FSM (acts only when the output register is loadable):
  - S_EMPTY, FIFO non-empty: pop C, load C[11:4], save nib=C[3:0], go S_NIB.
  - S_NIB, FIFO non-empty: pop D, load {nib,D[11:8]}, save tail=D[7:0], go S_TAIL.
  - S_TAIL: load tail, go S_EMPTY (no pop).
  - S_NIB, FIFO empty, flush pending: load {nib,4'b0}, go S_EMPTY.
  - Otherwise hold.
- Latency: code written at edge N into an empty FIFO with idle output gives first byte ByteValid=1 after edge N+1.
- Flush:
  - Strobe sets flush-pending.
  - Codes arriving before completion are still accepted and packed first.
  - Completion: flush-pending && S_EMPTY && FIFO empty && ByteValid=0. Then FlushDone pulses one cycle and flush-pending clears.
  - Flush with nothing buffered: FlushDone one cycle after the strobe.
  - Flush while already pending: no extra effect.
- Flush and CodeValid in the same cycle: the code is included before FlushDone.
- FIFO pointers wrap modulo FIFO_DEPTH; count is CLOG2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: LZW_CODE_PACKER_COUNT_EN.
- Defined: oByteCount increments by 1 on each accepted byte (ByteValid&&ByteReady), wraps modulo 2^COUNT_W, and is not cleared by Flush.
- Undefined: no counter logic; oByteCount tied to 0.

Test Plan:
- Codes 0xABC, 0x123, ByteReady=1 -> bytes 0xAB, 0xC1, 0x23 in order; first ByteValid one edge after FIFO write.
- Code 0x0FF then Flush -> bytes 0x0F, 0xF0; FlushDone one-cycle pulse after 0xF0 accepted; FSM back to S_EMPTY.
- Codes 0xFFF, 0x001 with ByteReady low 5 cycles between transfers -> oByte held stable while stalled; output sequence 0xFF, 0xF0, 0x01.
- FIFO_DEPTH=4, ByteReady=0, CodeValid on 6 consecutive cycles -> 5 codes accepted (1 in packer, 4 in FIFO), 6th dropped, CodeReady=0, Overflow=1. Releasing ByteReady drains 7 bytes plus the nibble held until next code/flush.
- Reset asserted mid-stream with 2 codes buffered and ByteValid=1 -> all outputs immediately reset values; subsequent code 0x456 + Flush -> 0x45, 0x60 only.
- With LZW_CODE_PACKER_COUNT_EN, 4 codes + Flush -> oByteCount=6; without the macro, oByteCount stays 0.

Source files
------------

// File: rtl/lzw_code_packer.sv
// lzw_code_packer
// Output stage for the LZW compressor. Buffers 12-bit dictionary codes in a
// small FIFO and packs them MSB-first into an 8-bit byte stream, so that two
// codes always become three bytes. A flush emits any leftover half-byte
// zero-padded and then pulses FlushDone.
//
// Ports:
//   Clk         rising-edge clock
//   Reset       asynchronous active-high reset, discards all buffered data
//   iCode       code from the datapath
//   CodeValid   one-cycle strobe, iCode valid
//   CodeReady   FIFO not full (from registered count)
//   Flush       one-cycle strobe, end of stream
//   FlushDone   one-cycle pulse once every buffered bit has been emitted
//   oByte       packed output byte
//   ByteValid   oByte valid
//   ByteReady   downstream accepts oByte
//   Overflow    sticky, a code arrived while the FIFO was full
//   oByteCount  accepted byte count
//
// Optional feature macro: LZW_CODE_PACKER_COUNT_EN
//   defined   -> oByteCount counts accepted bytes, wrapping, never cleared by Flush
//   undefined -> oByteCount tied to zero

module lzw_code_packer #(
   parameter int CODE_W     = 12,
   parameter int FIFO_DEPTH = 4,
   parameter int COUNT_W    = 24
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [CODE_W-1:0]  iCode,
   input  logic               CodeValid,
   output logic               CodeReady,
   input  logic               Flush,
   output logic               FlushDone,
   output logic [7:0]         oByte,
   output logic               ByteValid,
   input  logic               ByteReady,
   output logic               Overflow,
   output logic [COUNT_W-1:0] oByteCount
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_NIB   = 2'd1,
      S_TAIL  = 2'd2
   } state_t;

   logic [CODE_W-1:0] fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [CNT_W-1:0]  fifoCount;
   logic              fifoEmpty;
   logic [CODE_W-1:0] headCode;

   state_t            state;
   state_t            nextState;
   logic [3:0]        nib;
   logic [7:0]        tail;
   logic              flushPending;

   logic              push;
   logic              pop;
   logic              loadable;
   logic              loadOut;
   logic [7:0]        loadByte;
   logic              saveNib;
   logic              saveTail;
   logic              flushComplete;

   assign fifoEmpty     = (fifoCount == '0);
   assign CodeReady     = (fifoCount < DEPTH_C);
   assign push          = CodeValid && CodeReady;
   assign headCode      = fifoMem[rdPtr];
   assign loadable      = !ByteValid || ByteReady;
   assign flushComplete = flushPending && (state == S_EMPTY) && fifoEmpty && !ByteValid;

   // Code storage; contents need no reset because the count gates every read.
   always_ff @(posedge Clk) begin
      if (push) begin
         fifoMem[wrPtr] <= iCode;
      end
   end

   // FIFO pointers and occupancy. CodeReady comes from the registered count,
   // so a pop in the same cycle never lets a push into a full FIFO.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         if (push && !pop) begin
            fifoCount <= fifoCount + 1'b1;
         end else if (pop && !push) begin
            fifoCount <= fifoCount - 1'b1;
         end
      end
   end

   // Packer next-state logic. It only advances when the output register can
   // take a new byte, so a stalled consumer freezes the whole packer.
   always_comb begin
      nextState = state;
      pop       = 1'b0;
      loadOut   = 1'b0;
      loadByte  = 8'h00;
      saveNib   = 1'b0;
      saveTail  = 1'b0;
      if (loadable) begin
         case (state)
            S_EMPTY: begin
               if (!fifoEmpty) begin
                  pop       = 1'b1;
                  loadOut   = 1'b1;
                  loadByte  = headCode[11:4];
                  saveNib   = 1'b1;
                  nextState = S_NIB;
               end
            end
            S_NIB: begin
               if (!fifoEmpty) begin
                  pop       = 1'b1;
                  loadOut   = 1'b1;
                  loadByte  = {nib, headCode[11:8]};
                  saveTail  = 1'b1;
                  nextState = S_TAIL;
               end else if (flushPending) begin
                  loadOut   = 1'b1;
                  loadByte  = {nib, 4'b0000};
                  nextState = S_EMPTY;
               end
            end
            S_TAIL: begin
               loadOut   = 1'b1;
               loadByte  = tail;
               nextState = S_EMPTY;
            end
            default: begin
               nextState = S_EMPTY;
            end
         endcase
      end
   end

   // Packer state, saved partial code fragments and the output register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= S_EMPTY;
         nib       <= 4'h0;
         tail      <= 8'h00;
         oByte     <= 8'h00;
         ByteValid <= 1'b0;
      end else begin
         state <= nextState;
         if (saveNib) begin
            nib <= headCode[3:0];
         end
         if (saveTail) begin
            tail <= headCode[7:0];
         end
         if (loadOut) begin
            oByte     <= loadByte;
            ByteValid <= 1'b1;
         end else if (ByteReady) begin
            ByteValid <= 1'b0;
         end
      end
   end

   // Flush tracking. Completion waits until the packer, the FIFO and the
   // output register are all drained. A flush strobe landing on the
   // completion cycle is absorbed, since a flush was already pending.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         flushPending <= 1'b0;
         FlushDone    <= 1'b0;
         Overflow     <= 1'b0;
      end else begin
         FlushDone <= flushComplete;
         if (flushComplete) begin
            flushPending <= 1'b0;
         end else if (Flush) begin
            flushPending <= 1'b1;
         end
         if (CodeValid && !CodeReady) begin
            Overflow <= 1'b1;
         end
      end
   end

`ifdef LZW_CODE_PACKER_COUNT_EN
   // Accepted byte counter, wraps naturally at 2^COUNT_W.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         oByteCount <= '0;
      end else if (ByteValid && ByteReady) begin
         oByteCount <= oByteCount + 1'b1;
      end
   end
`else
   assign oByteCount = '0;
`endif

endmodule

// File: tb/tb_lzw_code_packer.sv
// tb_lzw_code_packer
// Directed bench for lzw_code_packer. Inputs are driven and outputs sampled
// on the falling clock edge so that every observation reflects the state
// registered at the preceding rising edge.

module tb_lzw_code_packer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [11:0] iCode;
   logic        CodeValid;
   logic        CodeReady;
   logic        Flush;
   logic        FlushDone;
   logic [7:0]  oByte;
   logic        ByteValid;
   logic        ByteReady;
   logic        Overflow;
   logic [23:0] oByteCount;

   int errorCount = 0;
   int checkCount = 0;

   logic [11:0] ovCodes   [6] = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666};
   logic [7:0]  drainBytes[7] = '{8'h11, 8'h12, 8'h22, 8'h33, 8'h34, 8'h44, 8'h55};
   logic [7:0]  cntBytes  [6] = '{8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h23, 8'h45};

   lzw_code_packer #(
      .CODE_W    (12),
      .FIFO_DEPTH(4),
      .COUNT_W   (24)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .iCode     (iCode),
      .CodeValid (CodeValid),
      .CodeReady (CodeReady),
      .Flush     (Flush),
      .FlushDone (FlushDone),
      .oByte     (oByte),
      .ByteValid (ByteValid),
      .ByteReady (ByteReady),
      .Overflow  (Overflow),
      .oByteCount(oByteCount)
   );

   // Free-running clock, 10 time units per period.
   always #5 Clk = ~Clk;

   // Safety net in case a wait loop is ever broken.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it and reports observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errorCount++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drive inputs for exactly one rising edge, then return them to idle.
   task automatic applyStimulus(input logic [11:0] code, input logic valid,
                                input logic flush);
      iCode     = code;
      CodeValid = valid;
      Flush     = flush;
      @(negedge Clk);
      CodeValid = 1'b0;
      Flush     = 1'b0;
   endtask

   // Wait (bounded) for a valid byte, check it, then step past its transfer.
   task automatic waitByte(input logic [7:0] expected, input string tag);
      int n = 0;
      while (!ByteValid && n < 20) begin
         @(negedge Clk);
         n++;
      end
      checkOutput({tag, "_valid"}, 32'(ByteValid), 32'd1);
      checkOutput(tag, 32'(oByte), 32'(expected));
      @(negedge Clk);
   endtask

   // Wait (bounded) for FlushDone, then confirm it is a single-cycle pulse.
   task automatic waitFlushDone(input string tag);
      int n = 0;
      while (!FlushDone && n < 20) begin
         @(negedge Clk);
         n++;
      end
      checkOutput(tag, 32'(FlushDone), 32'd1);
      @(negedge Clk);
      checkOutput({tag, "_pulse"}, 32'(FlushDone), 32'd0);
   endtask

   initial begin
      Reset     = 1'b1;
      iCode     = 12'h000;
      CodeValid = 1'b0;
      Flush     = 1'b0;
      ByteReady = 1'b0;
      repeat (2) @(negedge Clk);

      // Reset state
      checkOutput("rst_byte_valid", 32'(ByteValid), 32'd0);
      checkOutput("rst_obyte", 32'(oByte), 32'd0);
      checkOutput("rst_code_ready", 32'(CodeReady), 32'd1);
      checkOutput("rst_flush_done", 32'(FlushDone), 32'd0);
      checkOutput("rst_overflow", 32'(Overflow), 32'd0);
      checkOutput("rst_count", 32'(oByteCount), 32'd0);
      Reset = 1'b0;
      @(negedge Clk);

      // Two codes -> three bytes, first byte one edge after the FIFO write
      ByteReady = 1'b1;
      applyStimulus(12'hABC, 1'b1, 1'b0);
      checkOutput("t1_not_yet_valid", 32'(ByteValid), 32'd0);
      applyStimulus(12'h123, 1'b1, 1'b0);
      checkOutput("t1_first_valid", 32'(ByteValid), 32'd1);
      checkOutput("t1_byte0", 32'(oByte), 32'hAB);
      @(negedge Clk);
      checkOutput("t1_byte1", 32'(oByte), 32'hC1);
      @(negedge Clk);
      checkOutput("t1_byte2", 32'(oByte), 32'h23);
      @(negedge Clk);
      checkOutput("t1_idle", 32'(ByteValid), 32'd0);

      // Single code then flush -> padded half byte and FlushDone pulse
      applyStimulus(12'h0FF, 1'b1, 1'b0);
      applyStimulus(12'h000, 1'b0, 1'b1);
      checkOutput("t2_byte0", 32'(oByte), 32'h0F);
      checkOutput("t2_byte0_valid", 32'(ByteValid), 32'd1);
      @(negedge Clk);
      checkOutput("t2_byte1", 32'(oByte), 32'hF0);
      checkOutput("t2_done_early", 32'(FlushDone), 32'd0);
      @(negedge Clk);
      checkOutput("t2_drained", 32'(ByteValid), 32'd0);
      checkOutput("t2_done_wait", 32'(FlushDone), 32'd0);
      @(negedge Clk);
      checkOutput("t2_done", 32'(FlushDone), 32'd1);
      @(negedge Clk);
      checkOutput("t2_done_pulse", 32'(FlushDone), 32'd0);
      checkOutput("t2_state_empty", 32'(dut.state), 32'd0);

      // Backpressure: output held stable through five stalled cycles
      ByteReady = 1'b0;
      applyStimulus(12'hFFF, 1'b1, 1'b0);
      applyStimulus(12'h001, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("t3_hold_ff", 32'(oByte), 32'hFF);
         checkOutput("t3_hold_ff_valid", 32'(ByteValid), 32'd1);
         @(negedge Clk);
      end
      ByteReady = 1'b1;
      @(negedge Clk);
      ByteReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("t3_hold_f0", 32'(oByte), 32'hF0);
         @(negedge Clk);
      end
      ByteReady = 1'b1;
      @(negedge Clk);
      ByteReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("t3_hold_01", 32'(oByte), 32'h01);
         @(negedge Clk);
      end
      ByteReady = 1'b1;
      @(negedge Clk);
      checkOutput("t3_drained", 32'(ByteValid), 32'd0);

      // Overflow: six back-to-back codes while stalled, the sixth is dropped
      ByteReady = 1'b0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(ovCodes[i], 1'b1, 1'b0);
      end
      checkOutput("t4_code_ready", 32'(CodeReady), 32'd0);
      checkOutput("t4_overflow", 32'(Overflow), 32'd1);
      checkOutput("t4_head_byte", 32'(oByte), 32'h11);
      ByteReady = 1'b1;
      for (int i = 0; i < 7; i++) begin
         waitByte(drainBytes[i], "t4_drain");
      end
      checkOutput("t4_nib_held", 32'(ByteValid), 32'd0);
      checkOutput("t4_ready_again", 32'(CodeReady), 32'd1);
      checkOutput("t4_overflow_sticky", 32'(Overflow), 32'd1);
      applyStimulus(12'h000, 1'b0, 1'b1);
      waitByte(8'h50, "t4_pad");
      waitFlushDone("t4_flush_done");

      // Reset mid-stream discards buffered codes
      ByteReady = 1'b0;
      applyStimulus(12'h777, 1'b1, 1'b0);
      applyStimulus(12'h888, 1'b1, 1'b0);
      applyStimulus(12'h999, 1'b1, 1'b0);
      checkOutput("t5_pre_valid", 32'(ByteValid), 32'd1);
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("t5_rst_valid", 32'(ByteValid), 32'd0);
      checkOutput("t5_rst_obyte", 32'(oByte), 32'd0);
      checkOutput("t5_rst_ready", 32'(CodeReady), 32'd1);
      checkOutput("t5_rst_overflow", 32'(Overflow), 32'd0);
      @(negedge Clk);
      Reset     = 1'b0;
      ByteReady = 1'b1;
      @(negedge Clk);
      applyStimulus(12'h456, 1'b1, 1'b0);
      applyStimulus(12'h000, 1'b0, 1'b1);
      waitByte(8'h45, "t5_byte0");
      waitByte(8'h60, "t5_byte1");
      waitFlushDone("t5_flush_done");
      for (int i = 0; i < 3; i++) begin
         checkOutput("t5_no_extra", 32'(ByteValid), 32'd0);
         @(negedge Clk);
      end

      // Byte counter: four codes with the flush on the last code's cycle
      Reset = 1'b1;
      @(negedge Clk);
      Reset     = 1'b0;
      ByteReady = 1'b0;
      @(negedge Clk);
      applyStimulus(12'hABC, 1'b1, 1'b0);
      applyStimulus(12'hDEF, 1'b1, 1'b0);
      applyStimulus(12'h012, 1'b1, 1'b0);
      applyStimulus(12'h345, 1'b1, 1'b1);
      ByteReady = 1'b1;
      for (int i = 0; i < 6; i++) begin
         waitByte(cntBytes[i], "t6_byte");
      end
      waitFlushDone("t6_flush_done");
`ifdef LZW_CODE_PACKER_COUNT_EN
      checkOutput("t6_byte_count", 32'(oByteCount), 32'd6);
`else
      checkOutput("t6_byte_count", 32'(oByteCount), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
